// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the RAM arbiter state encoding.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    ISERVE,
    DSERVE
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Shares one RAM port between instruction fetch and data load/store; data has
// priority, a streak counter bounds fetch starvation, a watchdog aborts hung accesses.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = $bits(word_t),
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              iwait,
  output logic              dwait,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              mem_error
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
  localparam logic [WW-1:0] WCNT_LAST  = WW'(TIMEOUT - 1);

  arb_state_t    state;
  logic [SW-1:0] streak;
  logic [WW-1:0] wcnt;
  logic          dreq;
  logic          live;

  assign dreq = dREN | dWEN;
  // A serve state only counts toward timeout while its requester still asks.
  assign live = ((state == ISERVE) & iREN) | ((state == DSERVE) & dreq);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      streak    <= '0;
      wcnt      <= '0;
      mem_error <= 1'b0;
    end else begin
      mem_error <= 1'b0;
      case (state)
        IDLE: begin
          wcnt <= '0;
          if (dreq && (!iREN || (streak < STREAK_MAX))) begin
            state  <= DSERVE;
            streak <= !iREN ? '0 :
                      (streak == STREAK_MAX) ? streak : streak + SW'(1);
          end else if (iREN) begin
            state  <= ISERVE;
            streak <= '0;
          end
        end
        ISERVE, DSERVE: begin
          if (!live || ram_ready) begin
            state <= IDLE;
            wcnt  <= '0;
          end else if (wcnt == WCNT_LAST) begin
            state     <= IDLE;
            wcnt      <= '0;
            mem_error <= 1'b1;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        default: begin
          state <= IDLE;
          wcnt  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    iwait    = iREN;
    dwait    = dreq;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      ISERVE: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = !ram_ready;
        iload   = ramload;
      end
      DSERVE: begin
        ramaddr  = daddr;
        ramstore = dstore;
        // Write wins when both strobes are requested together.
        ramWEN   = dWEN;
        ramREN   = dREN & !dWEN;
        dwait    = !ram_ready;
        dload    = dWEN ? '0 : ramload;
      end
      default: begin
        iwait = iREN;
        dwait = dreq;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed requests, queued completions.
module tb_memory_arbiter;

  localparam logic [31:0] MAGIC = 32'h5A5A_0000;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic        ram_ready;
  logic        mem_error;
  logic        fixed_mode;
  logic [31:0] fixed_val;

  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  // RAM model: returns the address scrambled, or a fixed word when requested.
  assign ramload = fixed_mode ? fixed_val : (ramaddr ^ MAGIC);

  memory_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .mem_error(mem_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit is_data, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata);
    exp_t e;
    e.is_data = is_data;
    e.we      = we;
    e.addr    = addr;
    e.wdata   = wdata;
    e.rdata   = rdata;
    return e;
  endfunction

  task automatic check_completion(input bit side);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_completion: side %0d addr 0x%08h, expected no completion", side, ramaddr);
    end else begin
      e = exp_q.pop_front();
      chk("completion_side", {31'd0, side}, {31'd0, e.is_data});
      chk("completion_ramaddr", ramaddr, e.addr);
      if (!side) begin
        chk("i_ramREN", {31'd0, ramREN}, 32'd1);
        chk("iload", iload, e.rdata);
      end else if (e.we) begin
        chk("d_ramWEN", {31'd0, ramWEN}, 32'd1);
        chk("d_ramREN_on_write", {31'd0, ramREN}, 32'd0);
        chk("ramstore", ramstore, e.wdata);
      end else begin
        chk("d_ramREN", {31'd0, ramREN}, 32'd1);
        chk("dload", dload, e.rdata);
      end
    end
  endtask

  // Monitor: every reported completion must match the head of the queue.
  always @(negedge CLK) begin
    if (iREN && !iwait) check_completion(1'b0);
    if ((dREN || dWEN) && !dwait) check_completion(1'b1);
  end

  task automatic reset_dut();
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ram_ready = 1'b0;
    fixed_mode = 1'b0; fixed_val = '0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic do_i(input logic [31:0] a);
    bit ok = 1'b0;
    iREN = 1'b1; iaddr = a;
    for (int n = 0; n < 64; n++) begin
      @(negedge CLK);
      if (!iwait) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL i_request_timeout: addr 0x%08h still waiting, expected completion", a);
    end
    @(posedge CLK); #1;
  endtask

  task automatic do_d(input bit re, input bit we, input logic [31:0] a, input logic [31:0] wd);
    bit ok = 1'b0;
    dREN = re; dWEN = we; daddr = a; dstore = wd;
    for (int n = 0; n < 64; n++) begin
      @(negedge CLK);
      if (!dwait) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL d_request_timeout: addr 0x%08h still waiting, expected completion", a);
    end
    @(posedge CLK); #1;
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(posedge CLK);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_drain: %0d completions outstanding, expected 0", name, exp_q.size());
    end
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int pulses;

    // Reset with every request asserted: outputs must stay quiet.
    nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    iaddr = 32'h11; daddr = 32'h22; dstore = 32'h33; ram_ready = 1'b1;
    fixed_mode = 1'b1; fixed_val = 32'hFFFF_FFFF;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_dwait", {31'd0, dwait}, 32'd1);
    chk("rst_mem_error", {31'd0, mem_error}, 32'd0);

    // Test 1: single fetch, ready from the second cycle.
    reset_dut();
    fixed_mode = 1'b1; fixed_val = 32'hDEAD_BEEF;
    exp_q.push_back(mk(1'b0, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF));
    fork
      do_i(32'h40);
      begin
        @(negedge CLK);
        chk("t1_c1_iwait", {31'd0, iwait}, 32'd1);
        chk("t1_c1_ramREN", {31'd0, ramREN}, 32'd0);
        @(posedge CLK); #1 ram_ready = 1'b1;
        @(negedge CLK);
        chk("t1_c2_ramREN", {31'd0, ramREN}, 32'd1);
        chk("t1_c2_ramaddr", ramaddr, 32'h40);
        chk("t1_c2_iwait", {31'd0, iwait}, 32'd0);
      end
    join
    iREN = 1'b0; fixed_mode = 1'b0;
    wait_drain("t1");

    // Test 2: simultaneous fetch and store; data goes first.
    reset_dut();
    ram_ready = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b1, 32'h80, 32'h1234, 32'h0));
    exp_q.push_back(mk(1'b0, 1'b0, 32'h44, 32'h0, 32'h44 ^ MAGIC));
    fork
      begin do_d(1'b0, 1'b1, 32'h80, 32'h1234); dWEN = 1'b0; end
      begin do_i(32'h44); iREN = 1'b0; end
      begin
        @(negedge CLK); @(negedge CLK);
        chk("t2_ramWEN", {31'd0, ramWEN}, 32'd1);
        chk("t2_ramstore", ramstore, 32'h1234);
        chk("t2_iwait", {31'd0, iwait}, 32'd1);
        @(negedge CLK);
        chk("t2_idle_gap_iwait", {31'd0, iwait}, 32'd1);
        chk("t2_idle_gap_ramREN", {31'd0, ramREN}, 32'd0);
      end
    join
    wait_drain("t2");

    // Test 3: fetch held through five data reads; streak limit forces a fetch.
    reset_dut();
    ram_ready = 1'b1;
    for (int k = 0; k < 4; k++)
      exp_q.push_back(mk(1'b1, 1'b0, 32'h100 + 32'(4 * k), 32'h0, (32'h100 + 32'(4 * k)) ^ MAGIC));
    exp_q.push_back(mk(1'b0, 1'b0, 32'h10, 32'h0, 32'h10 ^ MAGIC));
    exp_q.push_back(mk(1'b1, 1'b0, 32'h110, 32'h0, 32'h110 ^ MAGIC));
    exp_q.push_back(mk(1'b0, 1'b0, 32'h14, 32'h0, 32'h14 ^ MAGIC));
    fork
      begin
        for (int k = 0; k < 5; k++) do_d(1'b1, 1'b0, 32'h100 + 32'(4 * k), 32'h0);
        dREN = 1'b0;
      end
      begin
        do_i(32'h10);
        do_i(32'h14);
        iREN = 1'b0;
      end
    join
    wait_drain("t3");

    // Test 4: RAM never ready; watchdog aborts, then the read is re-granted.
    reset_dut();
    exp_q.push_back(mk(1'b1, 1'b0, 32'h200, 32'h0, 32'h200 ^ MAGIC));
    dREN = 1'b1; daddr = 32'h200;
    for (int c = 1; c <= 19; c++) begin
      @(negedge CLK);
      chk($sformatf("t4_c%0d_mem_error", c), {31'd0, mem_error}, (c == 18) ? 32'd1 : 32'd0);
      chk($sformatf("t4_c%0d_ramREN", c), {31'd0, ramREN}, (c == 1 || c == 18) ? 32'd0 : 32'd1);
      chk($sformatf("t4_c%0d_dwait", c), {31'd0, dwait}, 32'd1);
    end
    @(posedge CLK); #1 ram_ready = 1'b1;
    wait_drain("t4");
    dREN = 1'b0;

    // Test 5a: read and write together resolve to a write.
    reset_dut();
    ram_ready = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b1, 32'h300, 32'hCAFE, 32'h0));
    fork
      do_d(1'b1, 1'b1, 32'h300, 32'hCAFE);
      begin
        @(negedge CLK); @(negedge CLK);
        chk("t5_both_ramWEN", {31'd0, ramWEN}, 32'd1);
        chk("t5_both_ramREN", {31'd0, ramREN}, 32'd0);
      end
    join
    dREN = 1'b0; dWEN = 1'b0;
    wait_drain("t5a");

    // Test 5b: read abandoned mid-serve.
    ram_ready = 1'b0;
    dREN = 1'b1; daddr = 32'h304;
    @(negedge CLK); @(negedge CLK);
    chk("t5_serve_ramREN", {31'd0, ramREN}, 32'd1);
    @(posedge CLK); #1 dREN = 1'b0;
    @(negedge CLK);
    chk("t5_abort_ramREN", {31'd0, ramREN}, 32'd0);
    chk("t5_abort_ramWEN", {31'd0, ramWEN}, 32'd0);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (c == 0) chk("t5_abort_idle_ramaddr", ramaddr, 32'h0);
      if (mem_error) pulses++;
    end
    chk("t5_abort_no_mem_error", 32'(pulses), 32'd0);

    // Test 6: reset during an instruction serve drops the access.
    reset_dut();
    iREN = 1'b1; iaddr = 32'h500;
    @(negedge CLK); @(negedge CLK);
    chk("t6_serve_ramREN", {31'd0, ramREN}, 32'd1);
    chk("t6_serve_ramaddr", ramaddr, 32'h500);
    @(posedge CLK); #1 nRST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("t6_rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("t6_rst_ramaddr", ramaddr, 32'h0);
    chk("t6_rst_iwait", {31'd0, iwait}, 32'd1);
    chk("t6_rst_mem_error", {31'd0, mem_error}, 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1; ram_ready = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 32'h500, 32'h0, 32'h500 ^ MAGIC));
    wait_drain("t6");
    iREN = 1'b0;

    repeat (3) @(posedge CLK);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
